// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : loader_pkg
//  Purpose : Shared types and constants for the instruction-memory loader.
//            The default widths are also used to size the datapath ROM.
//  Contents: state_t          - loader FSM states
//            DEF_ADDR_W       - default instruction-memory address width
//            DEF_DATA_W       - default instruction word width
//            BYTES_PER_WORD   - bytes packed into one default-width word
//            cnt_width()      - byte-counter width for a given bytes/word
//  Revision: 1.0 - initial release
// ============================================================================
package loader_pkg;

   localparam int DEF_ADDR_W     = 4;
   localparam int DEF_DATA_W     = 32;
   localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // A one-byte word still needs a 1-bit counter so the vector is legal.
   function automatic int cnt_width(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
//  Module  : word_packer
//  Purpose : Packs a byte stream MSB-first into DATA_W-bit words.
//  Ports   : clk          - clock
//            reset        - asynchronous active-low reset
//            i_clr        - clear shift register and byte counter
//            i_shift_en   - a byte is transferred this cycle
//            i_byte_in    - byte being transferred
//            o_word       - shift register contents (packed word)
//            o_word_full  - this transfer completes a word
//  Revision: 1.0 - initial release
// ============================================================================
module word_packer
   import loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_shift_en,
   input  logic [7:0]        i_byte_in,
   output logic [DATA_W-1:0] o_word,
   output logic              o_word_full
);

   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = cnt_width(BPW);
   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(BPW - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_next;
   logic [CNT_W-1:0]  r_cnt;

   generate
      if (DATA_W > 8) begin : g_multi_byte
         assign w_shift_next = {r_shift[DATA_W-9:0], i_byte_in};
      end else begin : g_single_byte
         assign w_shift_next = i_byte_in;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_clr) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_shift_en) begin
         r_shift <= w_shift_next;
         r_cnt   <= (r_cnt == c_LAST_IDX) ? '0 : r_cnt + c_CNT_ONE;
      end
   end

   // Asserted on the transfer that fills the word, so the FSM can move to
   // WRITE on the same edge the last byte lands in the shift register.
   assign o_word_full = i_shift_en && (r_cnt == c_LAST_IDX);
   assign o_word      = r_shift;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : imem_loader
//  Purpose : Instruction-memory writer. Packs a byte stream into words,
//            writes them to sequential addresses from 0, stalls the core
//            while loading and reports completion, count and XOR checksum.
//  Ports   : clk, reset       - clock, asynchronous active-low reset
//            i_start, i_len   - begin a load of i_len words (IDLE/DONE only)
//            i_byte_in/_valid, o_byte_ready - byte stream handshake
//            o_wr_en/_addr/_data            - instruction-memory write port
//            o_core_hold      - datapath stall while loading
//            o_done           - load complete (held until next start)
//            o_err_len        - last start rejected, len too large
//            o_word_count     - words written in current/last load
//            o_checksum       - XOR of words written in current/last load
//  Revision: 1.0 - initial release
// ============================================================================
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_len,
   input  logic [7:0]        i_byte_in,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_core_hold,
   output logic              o_done,
   output logic              o_err_len,
   output logic [ADDR_W:0]   o_word_count,
   output logic [DATA_W-1:0] o_checksum
);

   localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(2 ** ADDR_W);
   localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

   state_t            r_state;
   logic [ADDR_W:0]   r_len;
   logic              r_byte_ready;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_core_hold;
   logic              r_done;
   logic              r_err_len;
   logic [ADDR_W:0]   r_word_count;
   logic [DATA_W-1:0] r_checksum;

   logic              w_clr;
   logic              w_shift_en;
   logic              w_word_full;
   logic [DATA_W-1:0] w_word;

   // Any start seen in IDLE/DONE resets the packer, so a load never begins
   // with leftovers even if a previous one was cut short.
   assign w_clr      = i_start && (r_state == S_IDLE || r_state == S_DONE);
   // r_byte_ready is only ever high in RECV.
   assign w_shift_en = r_byte_ready && i_byte_valid;

   word_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_clr       (w_clr),
      .i_shift_en  (w_shift_en),
      .i_byte_in   (i_byte_in),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_byte_ready <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_core_hold  <= 1'b0;
         r_done       <= 1'b0;
         r_err_len    <= 1'b0;
         r_word_count <= '0;
         r_checksum   <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  if (i_len > c_DEPTH) begin
                     r_err_len <= 1'b1;
                     r_done    <= 1'b0;
                     r_state   <= S_IDLE;
                  end else if (i_len == '0) begin
                     r_word_count <= '0;
                     r_checksum   <= '0;
                     r_err_len    <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_len        <= i_len;
                     r_word_count <= '0;
                     r_checksum   <= '0;
                     r_wr_addr    <= '0;
                     r_err_len    <= 1'b0;
                     r_done       <= 1'b0;
                     r_core_hold  <= 1'b1;
                     r_byte_ready <= 1'b1;
                     r_state      <= S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (w_word_full) begin
                  r_byte_ready <= 1'b0;
                  r_wr_en      <= 1'b1;
                  r_state      <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The strobe is visible this cycle with the current address;
               // the address/count/checksum updates land after it.
               r_checksum   <= r_checksum ^ w_word;
               r_word_count <= r_word_count + c_CNT_ONE;
               r_wr_addr    <= r_wr_addr + c_ADDR_ONE;
               if ((r_word_count + c_CNT_ONE) == r_len) begin
                  r_core_hold <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_byte_ready <= 1'b1;
                  r_state      <= S_RECV;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_byte_ready = r_byte_ready;
   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = w_word;
   assign o_core_hold  = r_core_hold;
   assign o_done       = r_done;
   assign o_err_len    = r_err_len;
   assign o_word_count = r_word_count;
   assign o_checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_imem_loader
//  Purpose : Self-checking bench for imem_loader. Expected writes are queued
//            when bytes are planned and popped by a write monitor.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_start = 1'b0;
   logic [4:0]  i_len = '0;
   logic [7:0]  i_byte_in = '0;
   logic        i_byte_valid = 1'b0;
   logic        o_byte_ready;
   logic        o_wr_en;
   logic [3:0]  o_wr_addr;
   logic [31:0] o_wr_data;
   logic        o_core_hold;
   logic        o_done;
   logic        o_err_len;
   logic [4:0]  o_word_count;
   logic [31:0] o_checksum;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (i_start),
      .i_len        (i_len),
      .i_byte_in    (i_byte_in),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_core_hold  (o_core_hold),
      .o_done       (o_done),
      .o_err_len    (o_err_len),
      .o_word_count (o_word_count),
      .o_checksum   (o_checksum)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset && o_wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected wr_en", {31'd0, o_wr_en}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", {28'd0, o_wr_addr}, {28'd0, e.addr});
            check("wr_data", o_wr_data, e.data);
            check("ready low in WRITE", {31'd0, o_byte_ready}, 32'd0);
            check("hold during write", {31'd0, o_core_hold}, 32'd1);
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic do_start(input logic [4:0] len);
      i_start = 1'b1;
      i_len   = len;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      i_byte_valid = 1'b1;
      i_byte_in    = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_byte_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("byte_ready timeout", {31'd0, o_byte_ready}, 32'd1);
      @(posedge clk); #1;
      i_byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] addr, input logic [31:0] w);
      exp_q.push_back('{addr: addr, data: w});
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic idle(input int n);
      i_byte_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_done) break;
      end
      check("done", {31'd0, o_done}, 32'd1);
      check("hold low in DONE", {31'd0, o_core_hold}, 32'd0);
      check("scoreboard drained", exp_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " byte_ready"}, {31'd0, o_byte_ready}, 32'd0);
      check({tag, " wr_en"},      {31'd0, o_wr_en},      32'd0);
      check({tag, " wr_addr"},    {28'd0, o_wr_addr},    32'd0);
      check({tag, " wr_data"},    o_wr_data,             32'd0);
      check({tag, " core_hold"},  {31'd0, o_core_hold},  32'd0);
      check({tag, " done"},       {31'd0, o_done},       32'd0);
      check({tag, " err_len"},    {31'd0, o_err_len},    32'd0);
      check({tag, " word_count"}, {27'd0, o_word_count}, 32'd0);
      check({tag, " checksum"},   o_checksum,            32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      #12;
      check_reset_state("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic load, valid held high
      do_start(5'd2);
      check("hold after start", {31'd0, o_core_hold}, 32'd1);
      check("ready after start", {31'd0, o_byte_ready}, 32'd1);
      send_word(4'd0, 32'h01020304);
      send_word(4'd1, 32'hA0B1C2D3);
      wait_done();
      check("basic count", {27'd0, o_word_count}, 32'd2);
      check("basic checksum", o_checksum, 32'hA1B3C1D7);
      check("basic wr_addr", {28'd0, o_wr_addr}, 32'd2);

      // Gaps in byte_valid: 1,0,0,1,1,0,1
      do_start(5'd1);
      exp_q.push_back('{addr: 4'd0, data: 32'h11223344});
      send_byte(8'h11);
      idle(2);
      send_byte(8'h22);
      send_byte(8'h33);
      idle(1);
      send_byte(8'h44);
      @(negedge clk);
      check("gap latency wr_en", {31'd0, o_wr_en}, 32'd1);
      check("gap ready in WRITE", {31'd0, o_byte_ready}, 32'd0);
      wait_done();
      check("gap count", {27'd0, o_word_count}, 32'd1);
      check("gap checksum", o_checksum, 32'h11223344);

      // Full depth
      do_start(5'd16);
      for (int k = 0; k < 16; k++) send_word(4'(k), 32'(k));
      wait_done();
      check("full count", {27'd0, o_word_count}, 32'd16);
      check("full checksum", o_checksum, 32'h0);
      check("full wr_addr wrap", {28'd0, o_wr_addr}, 32'd0);

      // Length error
      do_start(5'd17);
      check("err_len set", {31'd0, o_err_len}, 32'd1);
      check("err done clear", {31'd0, o_done}, 32'd0);
      check("err hold", {31'd0, o_core_hold}, 32'd0);
      check("err ready", {31'd0, o_byte_ready}, 32'd0);
      i_byte_valid = 1'b1;
      i_byte_in    = 8'h77;
      idle(0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      i_byte_valid = 1'b0;
      check("err hold later", {31'd0, o_core_hold}, 32'd0);

      // Zero length
      do_start(5'd0);
      check("zero done", {31'd0, o_done}, 32'd1);
      check("zero err_len", {31'd0, o_err_len}, 32'd0);
      check("zero count", {27'd0, o_word_count}, 32'd0);
      check("zero checksum", o_checksum, 32'h0);
      check("zero hold", {31'd0, o_core_hold}, 32'd0);

      // Reset mid-load after 6 bytes
      do_start(5'd4);
      send_word(4'd0, 32'h10111213);
      send_byte(8'h14);
      send_byte(8'h15);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("midload");
      check("midload scoreboard", exp_q.size(), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      do_start(5'd1);
      send_word(4'd0, 32'hDEADBEEF);
      wait_done();
      check("post-reset count", {27'd0, o_word_count}, 32'd1);
      check("post-reset checksum", o_checksum, 32'hDEADBEEF);

      // Reload from DONE
      do_start(5'd1);
      check("reload done clear", {31'd0, o_done}, 32'd0);
      check("reload hold", {31'd0, o_core_hold}, 32'd1);
      check("reload count", {27'd0, o_word_count}, 32'd0);
      check("reload checksum", o_checksum, 32'h0);
      send_word(4'd0, 32'h5A5A0F0F);
      wait_done();
      check("reload final count", {27'd0, o_word_count}, 32'd1);
      check("reload final checksum", o_checksum, 32'h5A5A0F0F);

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction memory.
- Receives a byte stream over a valid/ready handshake and packs it MSB-first into 32-bit instruction words.
- Writes the words to sequential instruction-memory addresses starting at 0.
- Holds the core stalled while loading, then reports completion, word count and an XOR checksum. Sits between the host/serial front end and the instruction ROM write port.

Parameters:
- ADDR_W, 4, instruction-memory address width (depth 2**ADDR_W = 16 words)
- DATA_W, 32, instruction word width; must be a multiple of 8

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE
- len  input  ADDR_W+1  number of words to load; sampled with start
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle; transfer when byte_valid && byte_ready
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- core_hold  output  1  stall/reset request to the datapath while loading
- done  output  1  load completed; held until next accepted start
- err_len  output  1  last start rejected because len > 2**ADDR_W; held until next accepted start
- word_count  output  ADDR_W+1  words written in current/last load
- checksum  output  DATA_W  XOR of all words written in current/last load

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0, err_len=0, word_count=0, checksum=0, byte counter=0, shift register=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + start:
  - If len > 2**ADDR_W: err_len=1, done=0, stay in or go to IDLE.
  - If len == 0: clear count/checksum, done=1, go to DONE next cycle; core_hold never asserted.
  - Else: latch len, clear word_count, checksum, wr_addr and byte counter; err_len=0, done=0, core_hold=1; go to RECV.
- RECV:
  - byte_ready=1.
  - On each transfer: shift = {shift[DATA_W-9:0], byte_in}; byte counter++.
  - On the 4th transfer (counter wraps 3->0), go to WRITE.
  - byte_valid low: stay, no change.
  - start ignored.
- WRITE (exactly one cycle):
  - byte_ready=0; wr_en=1; wr_data=packed word; wr_addr=current address.
  - Same edge: checksum ^= word; word_count++; wr_addr++ takes effect after the strobe.
  - If word_count+1 == latched len: go to DONE, core_hold=0, done=1. Else go to RECV.
- Latency: wr_en is asserted the cycle after the 4th byte handshake. Peak throughput is 1 word per 5 cycles.
- wr_addr wrap: never exceeds 2**ADDR_W-1 because of the len check. With len == 2**ADDR_W, the final increment wraps wr_addr to 0 and it stays 0 in DONE.
- byte_ready=0 in IDLE, WRITE and DONE. Bytes offered there are not consumed.
- Asynchronous reset mid-load aborts immediately: core_hold drops, and partially packed bytes and words are discarded. Memory contents already written are left as is.
- wr_en is never asserted outside WRITE.
- Start in DONE behaves as in IDLE (reload).

Decomposition:
- Shared package loader_pkg:
  - state enum (IDLE, RECV, WRITE, DONE)
  - BYTES_PER_WORD = DATA_W/8
  - default ADDR_W/DATA_W constants shared with the datapath ROM sizing
- One sub-module: word_packer.
  - Contains the shift register and byte counter.
  - Inputs: clk, reset, clr, shift_en, byte_in.
  - Outputs: word, word_full.
- The FSM, address, count and checksum logic stay in imem_loader.

Test Plan:
- Basic load: len=2; bytes 01 02 03 04 A0 B1 C2 D3 with valid held high -> wr_en at addr 0 data 0x01020304, then addr 1 data 0xA0B1C2D3; done=1; word_count=2; checksum=0xA1B3C1D7; core_hold high from the cycle after start until the DONE cycle.
- Backpressure/gaps: len=1; byte_valid toggled 1,0,0,1,1,0,1 with bytes 11 22 33 44 -> exactly one write, data 0x11223344, 1 cycle after the last handshake; byte_ready=0 during WRITE.
- Full depth: len=16, word k = 0x000000kk -> 16 writes at addresses 0..15; word_count=16; checksum=0x00000000; wr_addr=0 in DONE.
- Length error and zero length:
  - len=17 -> err_len=1, no writes, core_hold stays 0.
  - Then len=0 -> done=1 next cycle, err_len=0, word_count=0.
- Reset mid-load: len=4, reset asserted after 6 bytes -> all outputs at reset values immediately. A new load of len=1 (bytes DE AD BE EF) then writes 0xDEADBEEF at addr 0, with no leftover bytes.
- Reload from DONE: after a completed load, start with len=1 -> done clears, core_hold reasserts, word_count and checksum restart from 0.
